// File: rtl/render_pkg.sv
// Shared types and helpers for the frame compositor: FSM state encoding,
// coordinate width derivation and the colour width.
package render_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SETTLE = 3'd2,
        STREAM = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int COLOUR_W = 3;

    // Enough bits to hold any x coordinate plus one spare bit.
    function automatic int calc_x_w(input int x_size);
        return $clog2(x_size) + 1;
    endfunction

    // Enough bits to hold any y coordinate plus one spare bit.
    function automatic int calc_y_w(input int y_size);
        return $clog2(y_size) + 1;
    endfunction

endpackage

// File: rtl/frame_compositor_layer_pick.sv
// Priority encoder: finds the lowest-numbered masked-in layer whose index is
// at or above the current layer index.
module layer_pick #(
    parameter int NUM_LAYERS = 3,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_LAYERS-1:0] mask,
    input  logic [IDX_W-1:0]      index,
    output logic                  found,
    output logic [IDX_W-1:0]      next_k
);

    // Scan downwards so the lowest qualifying layer is the last one written.
    always_comb begin
        found  = 1'b0;
        next_k = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            found  = found | (mask[i] & (i >= int'(index)));
            next_k = (mask[i] && (i >= int'(index))) ? IDX_W'(i) : next_k;
        end
    end

endmodule

// File: rtl/frame_compositor.sv
// Frame compositor: on each frame tick, runs the animator layers one at a
// time in priority order and forwards the active layer's pixels to the VGA
// adapter with a fixed one-cycle latency. Reports completion, overruns and
// per-layer timeouts.
module frame_compositor
    import render_pkg::*;
#(
    parameter int NUM_LAYERS    = 3,
    parameter int X_SIZE        = 320,
    parameter int Y_SIZE        = 240,
    parameter int LAYER_TIMEOUT = 131072
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     frame_tick,
    input  logic [NUM_LAYERS-1:0]                    layer_mask,
    output logic [NUM_LAYERS-1:0]                    layer_en,
    input  logic [NUM_LAYERS*calc_x_w(X_SIZE)-1:0]   layer_x,
    input  logic [NUM_LAYERS*calc_y_w(Y_SIZE)-1:0]   layer_y,
    input  logic [NUM_LAYERS*COLOUR_W-1:0]           layer_colour,
    input  logic [NUM_LAYERS-1:0]                    layer_plot,
    input  logic [NUM_LAYERS-1:0]                    layer_done,
    output logic [calc_x_w(X_SIZE)-1:0]              x,
    output logic [calc_y_w(Y_SIZE)-1:0]              y,
    output logic [COLOUR_W-1:0]                      colour,
    output logic                                     plot,
    output logic                                     busy,
    output logic                                     frame_done,
    output logic                                     overrun,
    output logic                                     timeout_err
);

    localparam int X_W   = calc_x_w(X_SIZE);
    localparam int Y_W   = calc_y_w(Y_SIZE);
    localparam int IDX_W = $clog2(NUM_LAYERS + 1);
    localparam int CNT_W = $clog2(LAYER_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAYER_TIMEOUT - 1);

    state_t                  state_r;
    logic [IDX_W-1:0]        index_r;
    logic [IDX_W-1:0]        cur_k_r;
    logic [NUM_LAYERS-1:0]   mask_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    pending_r;

    logic                    found_s;
    logic [IDX_W-1:0]        next_k_s;
    logic [X_W-1:0]          sel_x_s;
    logic [Y_W-1:0]          sel_y_s;
    logic [COLOUR_W-1:0]     sel_colour_s;
    logic                    sel_plot_s;
    logic                    sel_done_s;

    layer_pick #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .mask   (mask_r),
        .index  (index_r),
        .found  (found_s),
        .next_k (next_k_s)
    );

    // Select the active layer's pixel stream out of the packed animator buses.
    always_comb begin
        sel_x_s      = layer_x[cur_k_r*X_W +: X_W];
        sel_y_s      = layer_y[cur_k_r*Y_W +: Y_W];
        sel_colour_s = layer_colour[cur_k_r*COLOUR_W +: COLOUR_W];
        sel_plot_s   = layer_plot[cur_k_r];
        sel_done_s   = layer_done[cur_k_r];
    end

    // Frame sequencer with registered adapter outputs and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            index_r     <= '0;
            cur_k_r     <= '0;
            mask_r      <= '0;
            cnt_r       <= '0;
            pending_r   <= 1'b0;
            layer_en    <= '0;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            plot       <= 1'b0;

            // A tick while a frame is in flight queues at most one frame.
            if (frame_tick && (state_r != IDLE)) begin
                pending_r <= 1'b1;
                overrun   <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (frame_tick || pending_r) begin
                        state_r   <= SELECT;
                        mask_r    <= layer_mask;
                        index_r   <= '0;
                        busy      <= 1'b1;
                        pending_r <= 1'b0;
                    end
                end
                SELECT: begin
                    if (found_s) begin
                        state_r  <= SETTLE;
                        cur_k_r  <= next_k_s;
                        layer_en <= {{(NUM_LAYERS-1){1'b0}}, 1'b1} << next_k_s;
                        cnt_r    <= '0;
                    end else begin
                        state_r    <= FINISH;
                        frame_done <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Animator outputs are still stale this cycle; nothing is plotted.
                    state_r <= STREAM;
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                STREAM: begin
                    if (sel_done_s) begin
                        x        <= sel_x_s;
                        y        <= sel_y_s;
                        colour   <= sel_colour_s;
                        plot     <= sel_plot_s;
                        layer_en <= '0;
                        index_r  <= cur_k_r + IDX_W'(1);
                        state_r  <= SELECT;
                    end else if (cnt_r == CNT_LAST) begin
                        // Hung layer: abandon it without plotting this cycle's pixel.
                        timeout_err <= 1'b1;
                        layer_en    <= '0;
                        index_r     <= cur_k_r + IDX_W'(1);
                        state_r     <= SELECT;
                    end else begin
                        x      <= sel_x_s;
                        y      <= sel_y_s;
                        colour <= sel_colour_s;
                        plot   <= sel_plot_s;
                        cnt_r  <= cnt_r + CNT_W'(1);
                    end
                end
                FINISH: begin
                    if (pending_r || frame_tick) begin
                        state_r   <= SELECT;
                        mask_r    <= layer_mask;
                        index_r   <= '0;
                        busy      <= 1'b1;
                        pending_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    layer_en <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_compositor.sv
// Self-checking bench for frame_compositor: stub animators replay random
// pixel tables and a layer-order model predicts the adapter pixel stream.
module tb_frame_compositor;

    localparam int NL  = 3;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int TO  = 16;

    typedef logic [X_W+Y_W+2:0] pix_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 frame_tick;
    logic [NL-1:0]        layer_mask;
    logic [NL-1:0]        layer_en;
    logic [NL*X_W-1:0]    layer_x;
    logic [NL*Y_W-1:0]    layer_y;
    logic [NL*3-1:0]      layer_colour;
    logic [NL-1:0]        layer_plot;
    logic [NL-1:0]        layer_done;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic [2:0]           colour;
    logic                 plot;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;
    logic                 timeout_err;

    frame_compositor #(
        .NUM_LAYERS    (NL),
        .X_SIZE        (320),
        .Y_SIZE        (240),
        .LAYER_TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .layer_mask   (layer_mask),
        .layer_en     (layer_en),
        .layer_x      (layer_x),
        .layer_y      (layer_y),
        .layer_colour (layer_colour),
        .layer_plot   (layer_plot),
        .layer_done   (layer_done),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Stub animator pixel tables, written by the test tasks only.
    logic [X_W-1:0] px [NL][32];
    logic [Y_W-1:0] py [NL][32];
    logic [2:0]     pc [NL][32];
    logic           pp [NL][32];
    int             stub_len [NL];
    bit             never_done [NL];

    logic [X_W-1:0] sx [NL];
    logic [Y_W-1:0] sy [NL];
    logic [2:0]     sc [NL];
    logic [NL-1:0]  splot;
    logic [NL-1:0]  sdone;
    int             sp [NL];

    assign layer_x      = {sx[2], sx[1], sx[0]};
    assign layer_y      = {sy[2], sy[1], sy[0]};
    assign layer_colour = {sc[2], sc[1], sc[0]};
    assign layer_plot   = splot;
    assign layer_done   = sdone;

    // Registered stub animators: one table entry per enabled cycle, done with the last.
    always @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (reset || !layer_en[k]) begin
                sp[k]    <= 0;
                sx[k]    <= '0;
                sy[k]    <= '0;
                sc[k]    <= '0;
                splot[k] <= 1'b0;
                sdone[k] <= 1'b0;
            end else if (never_done[k] || sp[k] < stub_len[k]) begin
                sx[k]    <= px[k][sp[k] & 31];
                sy[k]    <= py[k][sp[k] & 31];
                sc[k]    <= pc[k][sp[k] & 31];
                splot[k] <= pp[k][sp[k] & 31];
                sdone[k] <= !never_done[k] && (sp[k] == stub_len[k] - 1);
                sp[k]    <= sp[k] + 1;
            end else begin
                splot[k] <= 1'b0;
                sdone[k] <= 1'b0;
            end
        end
    end

    // Pixel currently offered by whichever stub is plotting.
    pix_t stub_pix_s;
    logic stub_plot_s;
    always_comb begin
        stub_pix_s  = '0;
        stub_plot_s = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if (splot[k]) begin
                stub_plot_s = 1'b1;
                stub_pix_s  = {sx[k], sy[k], sc[k]};
            end
        end
    end

    // Monitor: records adapter writes, enable sequence and pulse counts.
    pix_t          obs_q[$];
    logic [NL-1:0] en_q[$];
    int            fd_count    = 0;
    int            busy_cycles = 0;
    int            en0_cycles  = 0;
    int            onehot_bad  = 0;
    int            lat_bad     = 0;
    logic [NL-1:0] prev_en     = '0;
    pix_t          prev_stub_pix = '0;
    logic          prev_stub_plot = 1'b0;

    always @(negedge clk) begin
        if (plot === 1'b1) begin
            obs_q.push_back({x, y, colour});
            if (!(prev_stub_plot && ({x, y, colour} == prev_stub_pix))) lat_bad <= lat_bad + 1;
        end
        if (layer_en != '0 && prev_en == '0) en_q.push_back(layer_en);
        if (layer_en[0] === 1'b1) en0_cycles <= en0_cycles + 1;
        if (frame_done === 1'b1) fd_count <= fd_count + 1;
        if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
        if ($countones(layer_en) > 1) onehot_bad <= onehot_bad + 1;
        prev_en        <= layer_en;
        prev_stub_pix  <= stub_pix_s;
        prev_stub_plot <= stub_plot_s;
    end

    int            tests_run    = 0;
    int            tests_failed = 0;
    pix_t          exp_q[$];
    logic [NL-1:0] exp_en[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic program_stubs(input int l0, input int l1, input int l2, input bit rand_plot);
        stub_len[0] = l0;
        stub_len[1] = l1;
        stub_len[2] = l2;
        for (int k = 0; k < NL; k++) begin
            never_done[k] = 1'b0;
            for (int p = 0; p < 32; p++) begin
                px[k][p] = X_W'($urandom_range(0, 319));
                py[k][p] = Y_W'($urandom_range(0, 239));
                pc[k][p] = 3'($urandom_range(0, 7));
                pp[k][p] = rand_plot ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    endtask

    // Reference: layers in ascending order; a hung layer yields TO-2 forwarded pixels.
    task automatic build_exp(input logic [NL-1:0] mask);
        exp_q.delete();
        exp_en.delete();
        for (int k = 0; k < NL; k++) begin
            if (mask[k]) begin
                int n;
                n = never_done[k] ? TO - 2 : stub_len[k];
                exp_en.push_back(3'b001 << k);
                for (int p = 0; p < n; p++) begin
                    if (pp[k][p]) exp_q.push_back({px[k][p], py[k][p], pc[k][p]});
                end
            end
        end
    endtask

    task automatic wait_frames(input int fd0, input int n, input int budget, input string name);
        int c = 0;
        while ((fd_count - fd0) < n && c < budget) begin
            tick();
            c++;
        end
        tests_run++;
        if ((fd_count - fd0) < n) begin
            tests_failed++;
            $display("FAIL %s_wait: frame_done pulses %0d, required %0d within %0d cycles", name, fd_count - fd0, n, budget);
        end
    endtask

    task automatic wait_en(input logic [NL-1:0] target, input int budget, input string name);
        int c = 0;
        while (layer_en !== target && c < budget) begin
            tick();
            c++;
        end
        tests_run++;
        if (layer_en !== target) begin
            tests_failed++;
            $display("FAIL %s_wait_en: layer_en %b, required %b within %0d cycles", name, layer_en, target, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_tick = 1'b0;
        layer_mask = '0;
        repeat (3) tick();
        tests_run += 9;
        if (layer_en !== 3'b000)  begin tests_failed++; $display("FAIL reset_layer_en: got %b, want 000", layer_en); end
        if (x !== 10'd0)          begin tests_failed++; $display("FAIL reset_x: got %0d, want 0", x); end
        if (y !== 9'd0)           begin tests_failed++; $display("FAIL reset_y: got %0d, want 0", y); end
        if (colour !== 3'd0)      begin tests_failed++; $display("FAIL reset_colour: got %0d, want 0", colour); end
        if (plot !== 1'b0)        begin tests_failed++; $display("FAIL reset_plot: got %b, want 0", plot); end
        if (busy !== 1'b0)        begin tests_failed++; $display("FAIL reset_busy: got %b, want 0", busy); end
        if (frame_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_frame_done: got %b, want 0", frame_done); end
        if (overrun !== 1'b0)     begin tests_failed++; $display("FAIL reset_overrun: got %b, want 0", overrun); end
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_err: got %b, want 0", timeout_err); end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    // One frame with a given mask; the mask is scrambled right after the tick.
    task automatic run_frame(input logic [NL-1:0] mask, input string name);
        int o0, e0, fd0, bad0, lat0;
        o0 = obs_q.size(); e0 = en_q.size(); fd0 = fd_count; bad0 = onehot_bad; lat0 = lat_bad;
        build_exp(mask);
        layer_mask = mask;
        pulse_tick();
        layer_mask = 3'($urandom);
        wait_frames(fd0, 1, 300, name);
        repeat (4) tick();
        tests_run++;
        if (obs_q.size() - o0 != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s_plot_count: got %0d, want %0d", name, obs_q.size() - o0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (o0 + i < obs_q.size()) begin
                tests_run++;
                if (obs_q[o0 + i] !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL %s_pixel%0d: got %h, want %h", name, i, obs_q[o0 + i], exp_q[i]);
                end
            end
        end
        tests_run++;
        if (en_q.size() - e0 != exp_en.size()) begin
            tests_failed++;
            $display("FAIL %s_en_count: got %0d, want %0d", name, en_q.size() - e0, exp_en.size());
        end
        for (int i = 0; i < exp_en.size(); i++) begin
            if (e0 + i < en_q.size()) begin
                tests_run++;
                if (en_q[e0 + i] !== exp_en[i]) begin
                    tests_failed++;
                    $display("FAIL %s_en_seq%0d: got %b, want %b", name, i, en_q[e0 + i], exp_en[i]);
                end
            end
        end
        tests_run += 5;
        if (fd_count - fd0 != 1)   begin tests_failed++; $display("FAIL %s_frame_done: got %0d pulses, want 1", name, fd_count - fd0); end
        if (busy !== 1'b0)         begin tests_failed++; $display("FAIL %s_busy_after: got %b, want 0", name, busy); end
        if (plot !== 1'b0)         begin tests_failed++; $display("FAIL %s_plot_after: got %b, want 0", name, plot); end
        if (onehot_bad != bad0)    begin tests_failed++; $display("FAIL %s_onehot: got %0d bad cycles, want 0", name, onehot_bad - bad0); end
        if (lat_bad != lat0)       begin tests_failed++; $display("FAIL %s_latency: got %0d late writes, want 0", name, lat_bad - lat0); end
    endtask

    task automatic test_full();
        program_stubs(4, 4, 4, 1'b0);
        run_frame(3'b111, "full");
        tests_run += 2;
        if (overrun !== 1'b0)     begin tests_failed++; $display("FAIL full_overrun: got %b, want 0", overrun); end
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL full_timeout_err: got %b, want 0", timeout_err); end
    endtask

    task automatic test_mask_101();
        program_stubs(4, 4, 4, 1'b0);
        run_frame(3'b101, "mask101");
    endtask

    task automatic test_empty();
        int o0, e0, fd0, b0;
        o0 = obs_q.size(); e0 = en_q.size(); fd0 = fd_count; b0 = busy_cycles;
        layer_mask = 3'b000;
        pulse_tick();
        repeat (6) tick();
        tests_run += 4;
        if (busy_cycles - b0 != 2)  begin tests_failed++; $display("FAIL empty_busy_cycles: got %0d, want 2", busy_cycles - b0); end
        if (fd_count - fd0 != 1)    begin tests_failed++; $display("FAIL empty_frame_done: got %0d, want 1", fd_count - fd0); end
        if (en_q.size() != e0)      begin tests_failed++; $display("FAIL empty_layer_en: got %0d enables, want 0", en_q.size() - e0); end
        if (obs_q.size() != o0)     begin tests_failed++; $display("FAIL empty_plot: got %0d writes, want 0", obs_q.size() - o0); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            program_stubs($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 1'b1);
            run_frame(3'($urandom), "random");
        end
    endtask

    task automatic test_timeout();
        int c0;
        program_stubs(4, $urandom_range(1, 6), $urandom_range(1, 6), 1'b1);
        never_done[0] = 1'b1;
        c0 = en0_cycles;
        run_frame(3'b011, "timeout");
        tests_run += 2;
        if (en0_cycles - c0 != TO) begin tests_failed++; $display("FAIL timeout_en0_cycles: got %0d, want %0d", en0_cycles - c0, TO); end
        if (timeout_err !== 1'b1)  begin tests_failed++; $display("FAIL timeout_err_flag: got %b, want 1", timeout_err); end
        never_done[0] = 1'b0;
    endtask

    task automatic test_overrun();
        int o0, fd0, n;
        program_stubs(5, 5, 5, 1'b1);
        o0 = obs_q.size(); fd0 = fd_count;
        build_exp(3'b111);
        layer_mask = 3'b111;
        pulse_tick();
        wait_en(3'b010, 100, "overrun");
        pulse_tick();
        repeat (2) tick();
        pulse_tick();
        wait_frames(fd0, 2, 400, "overrun");
        repeat (40) tick();
        n = exp_q.size();
        tests_run += 3;
        if (fd_count - fd0 != 2)              begin tests_failed++; $display("FAIL overrun_frames: got %0d, want 2", fd_count - fd0); end
        if (overrun !== 1'b1)                 begin tests_failed++; $display("FAIL overrun_flag: got %b, want 1", overrun); end
        if (obs_q.size() - o0 != 2 * n)       begin tests_failed++; $display("FAIL overrun_plot_count: got %0d, want %0d", obs_q.size() - o0, 2 * n); end
        for (int i = 0; i < 2 * n; i++) begin
            if (o0 + i < obs_q.size()) begin
                tests_run++;
                if (obs_q[o0 + i] !== exp_q[i % n]) begin
                    tests_failed++;
                    $display("FAIL overrun_pixel%0d: got %h, want %h", i, obs_q[o0 + i], exp_q[i % n]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int fd0;
        program_stubs(6, 6, 6, 1'b0);
        fd0 = fd_count;
        layer_mask = 3'b111;
        pulse_tick();
        wait_en(3'b100, 100, "reset_mid");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        tests_run += 6;
        if (layer_en !== 3'b000)  begin tests_failed++; $display("FAIL reset_mid_layer_en: got %b, want 000", layer_en); end
        if (plot !== 1'b0)        begin tests_failed++; $display("FAIL reset_mid_plot: got %b, want 0", plot); end
        if (busy !== 1'b0)        begin tests_failed++; $display("FAIL reset_mid_busy: got %b, want 0", busy); end
        if (overrun !== 1'b0)     begin tests_failed++; $display("FAIL reset_mid_overrun: got %b, want 0", overrun); end
        if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_timeout_err: got %b, want 0", timeout_err); end
        if (frame_done !== 1'b0)  begin tests_failed++; $display("FAIL reset_mid_frame_done: got %b, want 0", frame_done); end
        reset = 1'b0;
        repeat (30) tick();
        tests_run++;
        if (fd_count != fd0) begin tests_failed++; $display("FAIL reset_mid_no_done: got %0d pulses, want 0", fd_count - fd0); end
    endtask

    initial begin
        reset = 1'b1;
        frame_tick = 1'b0;
        layer_mask = '0;
        test_reset();
        repeat (5) tick();
        test_full();
        test_mask_101();
        test_empty();
        test_random();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
